// File: rtl/led_bar_driver.sv
// rtl/led_bar_driver.sv - LED bank driver: count resync/filter, dot/bar pattern, PWM brightness
//
// Purpose:
//   Takes the 3-bit count from the LED counter (a foreign clock domain), resynchronises it,
//   rejects values not seen on two consecutive samples, and drives an 8-LED bank as a single
//   dot or as a bar graph, dimmed by a glitch-free PWM.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   count_in     in   [2:0] count from the LED counter (asynchronous to clk)
//   mode         in   0 = dot, 1 = bar
//   brightness   in   [PWM_W-1:0] PWM duty, 0 = off, all-ones = fully on
//   led          out  [7:0] LED drive, 1 = lit
//   count_valid  out  first filtered count has been accepted
//   change_pulse out  one-cycle strobe when the accepted count changes value
//
// Configuration:
//   LED_FADE_EN  when defined, each count change restarts the brightness at 0 and ramps it
//                up by one step per PWM period towards the programmed brightness.

module led_bar_driver #(
  parameter int PWM_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       count_in,
  input  logic             mode,
  input  logic [PWM_W-1:0] brightness,
  output logic [7:0]       led,
  output logic             count_valid,
  output logic             change_pulse
);

  logic [2:0]             r_sync [SYNC_STAGES];
  // Tracks which synchroniser stages hold post-reset samples, so the reset value of the
  // chain is never mistaken for a filtered count.
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic [2:0]             r_cand;
  logic                   r_cand_vld;
  logic [2:0]             r_count_q;
  logic                   r_count_valid;
  logic                   r_change_pulse;
  logic [7:0]             r_pattern;
  logic [PWM_W-1:0]       r_pwm_cnt;
  logic [PWM_W-1:0]       r_duty_s;
  logic                   r_on;

  logic [2:0]             w_sync_q;
  logic                   w_accept;
  logic                   w_wrap;
  logic [PWM_W-1:0]       w_duty;
  logic                   w_on;
  logic [7:0]             w_pattern;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  // Multi-bit skew can show an intermediate code for a single cycle; requiring two equal
  // consecutive samples rejects it.
  assign w_accept = r_sync_vld[SYNC_STAGES-1] & r_cand_vld & (w_sync_q == r_cand);
  assign w_wrap   = (r_pwm_cnt == {PWM_W{1'b1}});

`ifdef LED_FADE_EN
  logic [PWM_W-1:0] r_fade_duty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fade_duty <= '0;
    end else if (r_change_pulse) begin
      r_fade_duty <= '0;
    end else if (w_wrap) begin
      if (r_fade_duty < r_duty_s) begin
        r_fade_duty <= r_fade_duty + PWM_W'(1);
      end else if (r_fade_duty > r_duty_s) begin
        r_fade_duty <= r_duty_s;
      end
    end
  end

  assign w_duty = r_fade_duty;
`else
  assign w_duty = r_duty_s;
`endif

  // All-ones duty is special-cased so full brightness is steady rather than 255/256.
  assign w_on = (w_duty == {PWM_W{1'b1}}) | (r_pwm_cnt < w_duty);

  always_comb begin
    w_pattern = '0;
    for (int i = 0; i < 8; i++) begin
      w_pattern[i] = mode ? (3'(i) <= r_count_q) : (3'(i) == r_count_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_sync_vld     <= '0;
      r_cand         <= '0;
      r_cand_vld     <= 1'b0;
      r_count_q      <= '0;
      r_count_valid  <= 1'b0;
      r_change_pulse <= 1'b0;
      r_pattern      <= '0;
      r_pwm_cnt      <= '0;
      r_duty_s       <= '0;
      r_on           <= 1'b0;
    end else begin
      r_sync[0] <= count_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};

      r_cand     <= w_sync_q;
      r_cand_vld <= r_sync_vld[SYNC_STAGES-1];

      // count_q resets to 0, so a first accept of 0 is silent and any other value strobes.
      r_change_pulse <= w_accept && (w_sync_q != r_count_q);
      if (w_accept) begin
        r_count_q     <= w_sync_q;
        r_count_valid <= 1'b1;
      end

      r_pattern <= w_pattern;

      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      // Brightness is sampled only at the period boundary so an edit never splits a period.
      if (w_wrap) r_duty_s <= brightness;
      r_on <= w_on;
    end
  end

  // Every term is a flop output; the pattern register is the last stage of the count path.
  assign led          = r_pattern & {8{r_count_valid & r_on}};
  assign count_valid  = r_count_valid;
  assign change_pulse = r_change_pulse;

endmodule

// File: tb/tb_led_bar_driver.sv
// tb/tb_led_bar_driver.sv - scoreboard testbench for led_bar_driver
module tb_led_bar_driver;
  localparam int S  = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    count_in;
  logic          mode;
  logic [PW-1:0] brightness;
  logic [7:0]    led;
  logic          count_valid;
  logic          change_pulse;

  led_bar_driver #(.PWM_W(PW), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .count_in(count_in), .mode(mode),
    .brightness(brightness), .led(led), .count_valid(count_valid),
    .change_pulse(change_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] led;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [7:0] bar(input int n);
    int v;
    v = (1 << (n + 1)) - 1;
    return v[7:0];
  endfunction

  function automatic logic [7:0] dot(input int n);
    int v;
    v = 1 << n;
    return v[7:0];
  endfunction

  task automatic push(input logic [7:0] pat);
    exp_t e;
    e.led = pat;
    e.cyc = cyc + S + 3;
    sb.push_back(e);
  endtask

  // Count changes right after a rising edge; a pulse is expected for the new value.
  task automatic step(input int v, input logic [7:0] pat);
    @(posedge clk);
    #1;
    count_in = 3'(v);
    push(pat);
    repeat (19) @(posedge clk);
  endtask

  // Monitor: on each change_pulse pop an expectation and check the LED pattern one cycle later.
  initial begin
    bit   pend;
    exp_t cur;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          pend = 0;
`ifdef LED_FADE_EN
          check("pulse_led_subset", int'(led | cur.led), int'(cur.led));
`else
          check("pulse_led", int'(led), int'(cur.led));
`endif
          check("pulse_latency", cyc, cur.cyc);
        end
        if (change_pulse) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", int'(change_pulse), 0);
          end else begin
            cur  = sb.pop_front();
            pend = 1;
          end
        end
      end
    end
  end

  initial begin
    int r, rise, bad, found, on;
    logic prev;
`ifdef LED_FADE_EN
    int fexp[6];
    fexp = '{0, 1, 2, 3, 4, 4};
`else
    int wa, b1, b2, wc, oth;
`endif
    count_in   = 3'd0;
    mode       = 1'b0;
    brightness = 8'hff;
    reset_n    = 1'b0;

    // Reset state and test 1: count 0 held, no pulse expected.
    @(posedge clk);
    #1;
    check("reset_led", int'(led), 0);
    check("reset_valid", int'(count_valid), 0);
    check("reset_pulse", int'(change_pulse), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    r = cyc;
    rise = -1000;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      @(posedge clk);
      #1;
      if (count_valid) rise = cyc;
    end
    check("t1_valid_rise", rise - r, S + 2);
`ifndef LED_FADE_EN
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("t1_led", int'(led), 8'h01);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led !== 8'h01) bad++;
    end
    check("t1_led_steady", bad, 0);
`else
    repeat (300) @(posedge clk);
`endif

    // Test 2: bar-mode walk 1..7.
    @(posedge clk);
    #1;
    mode = 1'b1;
    repeat (20) @(posedge clk);
    for (int n = 1; n < 8; n++) step(n, bar(n));

    // Test 3: 3 held, 7 for a single cycle, then 4 -> only 3 and 4 are accepted.
    step(3, bar(3));
    @(posedge clk);
    #1;
    count_in = 3'd7;
    @(posedge clk);
    #1;
    count_in = 3'd4;
    push(bar(4));
    repeat (19) @(posedge clk);

`ifndef LED_FADE_EN
    // Test 4: dot mode, count 5, 64/256 duty and a mid-period brightness edit.
    @(posedge clk);
    #1;
    mode = 1'b0;
    step(5, dot(5));
    brightness = 8'h40;
    repeat (300) @(posedge clk);
    found = 0;
    @(negedge clk);
    prev = led[5];
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(negedge clk);
      if (led[5] && !prev) found = 1;
      prev = led[5];
    end
    check("t4_period_found", found, 1);
    wa = 1; b1 = 0; b2 = 0; wc = 0; oth = 0;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      wa += int'(led[5]);
      if ((led & 8'hdf) != 8'h00) oth++;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      b1 += int'(led[5]);
      if ((led & 8'hdf) != 8'h00) oth++;
    end
    brightness = 8'h80;
    for (int i = 0; i < 156; i++) begin
      @(negedge clk);
      b2 += int'(led[5]);
      if ((led & 8'hdf) != 8'h00) oth++;
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      wc += int'(led[5]);
      if ((led & 8'hdf) != 8'h00) oth++;
    end
    check("t4_on_64", wa, 64);
    check("t4_next_period_start", b1, 64);
    check("t4_edit_no_glitch", b2, 0);
    check("t4_on_128_after_wrap", wc, 128);
    check("t4_other_leds_off", oth, 0);
    brightness = 8'hff;
    repeat (300) @(posedge clk);
    step(6, dot(6));
`else
    // Test 5: fade from 0 to brightness 4 over five periods after a 2 -> 3 change.
    @(posedge clk);
    #1;
    mode = 1'b0;
    brightness = 8'h04;
    step(2, dot(2));
    repeat (6 * 256) @(posedge clk);
    found = 0;
    @(negedge clk);
    prev = led[2];
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(negedge clk);
      if (led[2] && !prev) found = 1;
      prev = led[2];
    end
    check("t5_period_found", found, 1);
    for (int w = 0; w < 6; w++) begin
      on = 0;
      for (int i = 0; i < 256; i++) begin
        if (!(w == 0 && i == 0)) @(negedge clk);
        if (w == 0 && i == 10) begin
          count_in = 3'd3;
          push(dot(3));
        end
        on += int'(led[3]);
      end
      check($sformatf("t5_fade_period%0d", w), on, fexp[w]);
    end
    step(6, dot(6));
`endif

    // Test 6: asynchronous reset mid-operation, then recovery with count 6.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_led", int'(led), 0);
    check("t6_async_valid", int'(count_valid), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    r = cyc;
    push(8'h00);
    rise = -1000;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      @(posedge clk);
      #1;
      if (count_valid) rise = cyc;
    end
    check("t6_valid_rise", rise - r, S + 2);
`ifndef LED_FADE_EN
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("t6_led", int'(led), 8'h40);
`else
    repeat (10) @(posedge clk);
`endif

    repeat (5) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
